reaction_timer_mux: RTL and testbench
=====================================

// Module: reaction_timer_mux
// PURPOSE
//  Parametrised reaction-time game core with a multiplexed N-digit seven-segment display driver.
//  - FSM: START -> READY (random delay) -> PLAY (BCD timing) -> FINISH (hold result).
//  - Built-in tick and scan dividers replace the fixed divide-by-4 and divide-by-2M blocks.
//  - Sits between the top-level switch/button inputs and the uo_out display pins.
// PARAMETERS
//  NUM_DIGITS  2          number of BCD digits counted and scanned (1..8)
//  TICK_DIV    2_000_000  clk cycles per timing tick (0.1 s at 20 MHz), >=2
//  SCAN_DIV    4          clk cycles per display digit slot, >=1
//  DELAY_MIN   10         minimum READY delay in ticks, >=1
// PORTS
//  clk        in   1           system clock
//  rst_n      in   1           asynchronous active-low reset
//  ena        in   1           design enable; low freezes all state
//  start_i    in   1           start/restart button, asynchronous, active-high
//  react_i    in   1           reaction button, asynchronous, active-high
//  seg_o      out  7           segments {g,f,e,d,c,b,a}, active-high
//  dig_sel_o  out  NUM_DIGITS  one-hot digit enable; bit 0 = least-significant digit
//  state_o    out  2           START=0, READY=1, PLAY=2, FINISH=3
//  early_o    out  1           react pressed during READY (false start)
//  timeout_o  out  1           count saturated at all 9s
// BEHAVIOUR
//  Reset values: state START, BCD count 0, seg_o 0, dig_sel_o 1, early_o/timeout_o 0, LFSR 8'hA5.
//  Inputs: 2-flop synchroniser, then rising-edge detect. Edge is acted on one cycle after the second flop.
//  ena low: synchronisers, dividers, LFSR, FSM and count all hold; seg_o forced to 0.
//  LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1, advances every clk while ena is high.
//  Tick counter: $clog2(TICK_DIV) bits, counts 0..TICK_DIV-1, wraps.
//   - One-cycle tick at TICK_DIV-1.
//   - Cleared on entry to READY and to PLAY, so the first tick comes TICK_DIV cycles after entry.
//  FSM:
//   START: display blank. start edge -> READY. Clears count, early_o and timeout_o. Latches delay = DELAY_MIN + lfsr[3:0].
//   READY: display blank. Delay decrements per tick; reaching 0 -> PLAY.
//          react edge -> FINISH with early_o=1 and count 0. react has priority over delay expiry in the same cycle.
//   PLAY: count increments by 1 (BCD, ripple carry) per tick.
//         react edge -> FINISH; a tick in the same cycle is not added.
//         tick while count is all 9s -> count holds, timeout_o=1, FINISH.
//   FINISH: display the held count. start edge -> READY, with the same clears and latch as START.
//  Simultaneous edges: start beats react in START and FINISH. start is ignored in READY and PLAY.
//  Display mode: digits shown in PLAY and FINISH.
//   - early_o=1 shows segment g only (dash) on every digit.
//   - Codes: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F. Blank = 00.
//  Scan: scan counter wraps every SCAN_DIV cycles, then the digit index advances; NUM_DIGITS-1 wraps to 0.
//   - dig_sel_o and seg_o are registered and update together: no ghosting, one cycle of latency from the index.
//  Reset mid-operation: immediate return to reset values; no result is retained.
// CONFIGURATION
//  BEST_SCORE_EN defined:
//   - Adds a best-time register, reset to all 9s.
//   - On PLAY -> FINISH via react (not timeout): best = min(best, count).
//   - In FINISH, while the synchronised react_i is held high, the display shows best instead of count.
//  BEST_SCORE_EN undefined: no register; react_i is ignored in START and FINISH.
// TESTING  (NUM_DIGITS=2, TICK_DIV=4, SCAN_DIV=2, DELAY_MIN=3)
//  1. Reset and scan: rst_n low then high -> state 0, seg_o 00, dig_sel_o 01; dig_sel_o toggles 01/10 every 2 cycles.
//  2. Normal run: start edge, delay from model LFSR, react after 7 PLAY ticks -> FINISH, digits 0 and 7 shown (3F/07).
//  3. False start: react edge during READY -> FINISH, early_o=1, seg_o=40 on both digits; start edge -> READY, early_o=0.
//  4. Timeout: no react for 100 PLAY ticks -> count 99, timeout_o=1, FINISH, both digits 6F.
//  5. ena low for 50 cycles mid-PLAY -> count, state and dig_sel_o unchanged, seg_o 00; resumes exactly on ena high.
//  6. BEST_SCORE_EN: runs of 12 then 5 then 9 -> holding react in FINISH shows 05. Async reset mid-PLAY -> state 0 same cycle.

Source files
------------

// File: rtl/reaction_timer_mux_if.sv
// reaction_timer_mux_if: bundles the game-core control inputs and display/status outputs.
// Signals:
//   ena        design enable; low freezes the core
//   start_i    start/restart button (asynchronous)
//   react_i    reaction button (asynchronous)
//   seg_o      segments {g,f,e,d,c,b,a}, active-high
//   dig_sel_o  one-hot digit enable, bit 0 = least-significant digit
//   state_o    START=0, READY=1, PLAY=2, FINISH=3
//   early_o    false start flag
//   timeout_o  count saturated flag
// Modports: master drives the inputs, slave is the game core.
interface reaction_timer_mux_if #(
   parameter int unsigned NUM_DIGITS = 2
) ();
   logic                  ena;
   logic                  start_i;
   logic                  react_i;
   logic [6:0]            seg_o;
   logic [NUM_DIGITS-1:0] dig_sel_o;
   logic [1:0]            state_o;
   logic                  early_o;
   logic                  timeout_o;

   modport master (
      output ena, start_i, react_i,
      input  seg_o, dig_sel_o, state_o, early_o, timeout_o
   );

   modport slave (
      input  ena, start_i, react_i,
      output seg_o, dig_sel_o, state_o, early_o, timeout_o
   );
endinterface

// File: rtl/reaction_timer_mux.sv
// reaction_timer_mux: reaction-time game core (START -> READY -> PLAY -> FINISH) with a
// BCD reaction counter and a multiplexed NUM_DIGITS seven-segment display driver.
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    reaction_timer_mux_if.slave (ena, start_i, react_i in; seg_o, dig_sel_o,
//          state_o, early_o, timeout_o out)
// Optional feature macro: BEST_SCORE_EN adds a best-time register that is displayed in
// FINISH while the synchronised react_i is held high.
module reaction_timer_mux #(
   parameter int unsigned NUM_DIGITS = 2,
   parameter int unsigned TICK_DIV   = 2_000_000,
   parameter int unsigned SCAN_DIV   = 4,
   parameter int unsigned DELAY_MIN  = 10
) (
   input logic                 clk,
   input logic                 rst_n,
   reaction_timer_mux_if.slave bus
);
   localparam int unsigned CW = NUM_DIGITS * 4;
   localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int unsigned SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int unsigned DW = $clog2(DELAY_MIN + 16);

   localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
   localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
   localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);
   localparam logic [CW-1:0] NINES     = {NUM_DIGITS{4'h9}};

   localparam logic [1:0] S_START  = 2'd0;
   localparam logic [1:0] S_READY  = 2'd1;
   localparam logic [1:0] S_PLAY   = 2'd2;
   localparam logic [1:0] S_FINISH = 2'd3;

   logic [1:0]            r_start_s, r_react_s;
   logic                  r_start_d, r_react_d;
   logic [7:0]            r_lfsr;
   logic [TW-1:0]         r_tick;
   logic [SW-1:0]         r_scan;
   logic [IW-1:0]         r_idx;
   logic [1:0]            r_state, w_state_nx;
   logic [CW-1:0]         r_count, w_count_nx;
   logic [DW-1:0]         r_delay, w_delay_nx;
   logic                  r_early, w_early_nx;
   logic                  r_timeout, w_timeout_nx;
   logic [6:0]            r_seg, w_seg_nx;
   logic [NUM_DIGITS-1:0] r_dig_sel, w_dig_sel_nx;
   logic                  w_start_edge, w_react_edge, w_tick, w_tick_clr, w_arm;
   logic [CW-1:0]         w_disp_val;
   logic [3:0]            w_digit;
`ifdef BEST_SCORE_EN
   logic [CW-1:0]         r_best, w_best_nx;
`endif

   // BCD increment with ripple carry across digits
   function automatic logic [CW-1:0] bcd_inc(input logic [CW-1:0] v);
      logic [CW-1:0] res;
      logic          carry;
      res   = v;
      carry = 1'b1;
      for (int i = 0; i < int'(NUM_DIGITS); i++) begin
         if (carry) begin
            if (v[i*4 +: 4] == 4'd9) begin
               res[i*4 +: 4] = 4'd0;
            end else begin
               res[i*4 +: 4] = v[i*4 +: 4] + 4'd1;
               carry         = 1'b0;
            end
         end
      end
      return res;
   endfunction

   function automatic logic [6:0] seg_code(input logic [3:0] d);
      logic [6:0] code;
      case (d)
         4'd0:    code = 7'h3F;
         4'd1:    code = 7'h06;
         4'd2:    code = 7'h5B;
         4'd3:    code = 7'h4F;
         4'd4:    code = 7'h66;
         4'd5:    code = 7'h6D;
         4'd6:    code = 7'h7D;
         4'd7:    code = 7'h07;
         4'd8:    code = 7'h7F;
         4'd9:    code = 7'h6F;
         default: code = 7'h00;
      endcase
      return code;
   endfunction

   assign w_start_edge = r_start_s[1] & ~r_start_d;
   assign w_react_edge = r_react_s[1] & ~r_react_d;
   assign w_tick       = (r_tick == TICK_LAST);

   // Input synchronisers, edge history, LFSR and tick divider
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_start_s <= '0;
         r_react_s <= '0;
         r_start_d <= 1'b0;
         r_react_d <= 1'b0;
         r_lfsr    <= 8'hA5;
         r_tick    <= '0;
      end else if (bus.ena) begin
         r_start_s <= {r_start_s[0], bus.start_i};
         r_react_s <= {r_react_s[0], bus.react_i};
         r_start_d <= r_start_s[1];
         r_react_d <= r_react_s[1];
         r_lfsr    <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
         if (w_tick_clr || w_tick) r_tick <= '0;
         else                      r_tick <= r_tick + TW'(1);
      end
   end

   // Next-state and datapath updates; w_arm covers the shared START/FINISH restart
   always_comb begin
      w_state_nx   = r_state;
      w_count_nx   = r_count;
      w_delay_nx   = r_delay;
      w_early_nx   = r_early;
      w_timeout_nx = r_timeout;
      w_tick_clr   = 1'b0;
      w_arm        = 1'b0;
`ifdef BEST_SCORE_EN
      w_best_nx    = r_best;
`endif
      case (r_state)
         S_START: begin
            if (w_start_edge) w_arm = 1'b1;
         end
         S_READY: begin
            if (w_react_edge) begin
               w_state_nx = S_FINISH;
               w_early_nx = 1'b1;
               w_count_nx = '0;
            end else if (w_tick) begin
               w_delay_nx = r_delay - DW'(1);
               if (r_delay <= DW'(1)) begin
                  w_state_nx = S_PLAY;
                  w_tick_clr = 1'b1;
               end
            end
         end
         S_PLAY: begin
            if (w_react_edge) begin
               w_state_nx = S_FINISH;
`ifdef BEST_SCORE_EN
               if (r_count < r_best) w_best_nx = r_count;
`endif
            end else if (w_tick) begin
               if (r_count == NINES) begin
                  w_timeout_nx = 1'b1;
                  w_state_nx   = S_FINISH;
               end else begin
                  w_count_nx = bcd_inc(r_count);
               end
            end
         end
         default: begin
            if (w_start_edge) w_arm = 1'b1;
         end
      endcase
      if (w_arm) begin
         w_state_nx   = S_READY;
         w_count_nx   = '0;
         w_early_nx   = 1'b0;
         w_timeout_nx = 1'b0;
         w_delay_nx   = DW'(DELAY_MIN) + DW'(r_lfsr[3:0]);
         w_tick_clr   = 1'b1;
      end
   end

   // FSM and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_START;
         r_count   <= '0;
         r_delay   <= '0;
         r_early   <= 1'b0;
         r_timeout <= 1'b0;
`ifdef BEST_SCORE_EN
         r_best    <= NINES;
`endif
      end else if (bus.ena) begin
         r_state   <= w_state_nx;
         r_count   <= w_count_nx;
         r_delay   <= w_delay_nx;
         r_early   <= w_early_nx;
         r_timeout <= w_timeout_nx;
`ifdef BEST_SCORE_EN
         r_best    <= w_best_nx;
`endif
      end
   end

   // Segment pattern and digit enable for the current scan index
   always_comb begin
      w_disp_val = r_count;
`ifdef BEST_SCORE_EN
      if (r_state == S_FINISH && r_react_s[1]) w_disp_val = r_best;
`endif
      w_digit      = 4'd0;
      w_dig_sel_nx = '0;
      for (int i = 0; i < int'(NUM_DIGITS); i++) begin
         if (IW'(i) == r_idx) begin
            w_digit         = w_disp_val[i*4 +: 4];
            w_dig_sel_nx[i] = 1'b1;
         end
      end
      w_seg_nx = 7'h00;
      if (r_state == S_PLAY || r_state == S_FINISH) begin
         w_seg_nx = r_early ? 7'h40 : seg_code(w_digit);
      end
   end

   // Scan divider and registered display; seg and digit enable change on the same edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_scan    <= '0;
         r_idx     <= '0;
         r_seg     <= 7'h00;
         r_dig_sel <= NUM_DIGITS'(1);
      end else if (!bus.ena) begin
         r_seg <= 7'h00;
      end else begin
         r_seg     <= w_seg_nx;
         r_dig_sel <= w_dig_sel_nx;
         if (r_scan == SCAN_LAST) begin
            r_scan <= '0;
            r_idx  <= (r_idx == IDX_LAST) ? '0 : r_idx + IW'(1);
         end else begin
            r_scan <= r_scan + SW'(1);
         end
      end
   end

   assign bus.seg_o     = r_seg;
   assign bus.dig_sel_o = r_dig_sel;
   assign bus.state_o   = r_state;
   assign bus.early_o   = r_early;
   assign bus.timeout_o = r_timeout;
endmodule

// File: tb/tb_reaction_timer_mux.sv
// tb_reaction_timer_mux: randomized self-checking bench for reaction_timer_mux
// (NUM_DIGITS=2, TICK_DIV=4, SCAN_DIV=2, DELAY_MIN=3). Define BEST_SCORE_EN to add the
// best-score scenario.
`timescale 1ns/1ps
module tb_reaction_timer_mux;
   localparam int unsigned ND   = 2;
   localparam int unsigned TD   = 4;
   localparam int unsigned SD   = 2;
   localparam int unsigned DMIN = 3;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   int         n_vec = 0;
   int         n_err = 0;
   logic [7:0] m_lfsr;
   logic [6:0] codes [10];

   reaction_timer_mux_if #(.NUM_DIGITS(ND)) bus ();

   reaction_timer_mux #(
      .NUM_DIGITS(ND),
      .TICK_DIV  (TD),
      .SCAN_DIV  (SD),
      .DELAY_MIN (DMIN)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   // Reference LFSR: x^8+x^6+x^5+x^4+1, one step per enabled clock, seed A5
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n)       m_lfsr <= 8'hA5;
      else if (bus.ena) m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
   end

   // Expected segments for the digit currently enabled; 8'hFF flags an illegal enable
   function automatic logic [7:0] exp_seg(input logic [ND-1:0] sel, input int tens,
                                          input int ones, input logic dash);
      int d;
      if (sel == 2'b01)      d = ones;
      else if (sel == 2'b10) d = tens;
      else                   return 8'hFF;
      if (dash) return 8'h40;
      return {1'b0, codes[d]};
   endfunction

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Press start from a negedge; returns the delay the core latches; ends just after READY entry
   task automatic do_start(output int d);
      bus.start_i = 1'b1;
      step(2);
      d = int'(DMIN) + int'(m_lfsr[3:0]);
      step(1);
      bus.start_i = 1'b0;
   endtask

   task automatic test_reset;
      logic [ND-1:0] exp_sel;
      bus.ena     = 1'b1;
      bus.start_i = 1'b0;
      bus.react_i = 1'b0;
      rst_n       = 1'b0;
      #22;
      n_vec++;
      if (bus.state_o !== 2'd0 || bus.seg_o !== 7'h00 || bus.dig_sel_o !== 2'b01) begin
         n_err++;
         $display("FAIL reset_out: state=%0d seg=%h sel=%b expected 0/00/01", bus.state_o, bus.seg_o, bus.dig_sel_o);
      end
      n_vec++;
      if (bus.early_o !== 1'b0 || bus.timeout_o !== 1'b0) begin
         n_err++;
         $display("FAIL reset_flags: early=%b timeout=%b expected 0/0", bus.early_o, bus.timeout_o);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int n = 1; n <= 12; n++) begin
         step(1);
         exp_sel = '0;
         exp_sel[((n - 1) / int'(SD)) % int'(ND)] = 1'b1;
         n_vec++;
         if (bus.dig_sel_o !== exp_sel || bus.seg_o !== 7'h00 || bus.state_o !== 2'd0) begin
            n_err++;
            $display("FAIL reset_scan[%0d]: sel=%b seg=%h state=%0d expected %b/00/0", n, bus.dig_sel_o, bus.seg_o, bus.state_o, exp_sel);
         end
      end
   endtask

   task automatic test_normal_run;
      int d;
      int j;
      do_start(d);
      n_vec++;
      if (bus.state_o !== 2'd1 || bus.early_o !== 1'b0 || bus.timeout_o !== 1'b0) begin
         n_err++;
         $display("FAIL normal_ready: state=%0d early=%b timeout=%b expected 1/0/0", bus.state_o, bus.early_o, bus.timeout_o);
      end
      step(4 * d - 1);
      n_vec++;
      if (bus.state_o !== 2'd1) begin
         n_err++;
         $display("FAIL normal_delay_hold: state=%0d expected 1 (delay %0d)", bus.state_o, d);
      end
      step(1);
      n_vec++;
      if (bus.state_o !== 2'd2) begin
         n_err++;
         $display("FAIL normal_play_entry: state=%0d expected 2 (delay %0d)", bus.state_o, d);
      end
      j = int'($urandom_range(0, 3));
      step(26 + j);
      bus.react_i = 1'b1;
      step(3);
      n_vec++;
      if (bus.state_o !== 2'd3 || bus.early_o !== 1'b0 || bus.timeout_o !== 1'b0) begin
         n_err++;
         $display("FAIL normal_finish: state=%0d early=%b timeout=%b expected 3/0/0", bus.state_o, bus.early_o, bus.timeout_o);
      end
      bus.react_i = 1'b0;
      step(4);
      for (int c = 0; c < int'(2 * SD * ND); c++) begin
         step(1);
         n_vec++;
         if ({1'b0, bus.seg_o} !== exp_seg(bus.dig_sel_o, 0, 7, 1'b0)) begin
            n_err++;
            $display("FAIL normal_disp: seg=%h sel=%b expected %h", bus.seg_o, bus.dig_sel_o, exp_seg(bus.dig_sel_o, 0, 7, 1'b0));
         end
      end
   endtask

   task automatic test_random_runs;
      int d;
      int s;
      int cnt;
      for (int r = 0; r < 5; r++) begin
         do_start(d);
         step(4 * d);
         s = int'($urandom_range(0, 60));
         // react lands s+3 enabled edges after PLAY entry; ticks fall every TD edges
         cnt = (s + 2) / int'(TD);
         step(s);
         bus.react_i = 1'b1;
         step(3);
         n_vec++;
         if (bus.state_o !== 2'd3 || bus.timeout_o !== 1'b0 || bus.early_o !== 1'b0) begin
            n_err++;
            $display("FAIL rand_finish[%0d]: state=%0d timeout=%b early=%b expected 3/0/0", r, bus.state_o, bus.timeout_o, bus.early_o);
         end
         bus.react_i = 1'b0;
         step(4);
         for (int c = 0; c < int'(2 * SD * ND); c++) begin
            step(1);
            n_vec++;
            if ({1'b0, bus.seg_o} !== exp_seg(bus.dig_sel_o, cnt / 10, cnt % 10, 1'b0)) begin
               n_err++;
               $display("FAIL rand_disp[%0d]: seg=%h sel=%b expected %h (count %0d)", r, bus.seg_o, bus.dig_sel_o, exp_seg(bus.dig_sel_o, cnt / 10, cnt % 10, 1'b0), cnt);
            end
         end
      end
   endtask

   task automatic test_false_start;
      int d;
      int r;
      do_start(d);
      for (int it = 0; it < 3; it++) begin
         // first pass lands react on the delay-expiry edge, later passes at random
         r = (it == 0) ? 4 * d - 3 : int'($urandom_range(0, 4 * d - 3));
         step(r);
         bus.react_i = 1'b1;
         step(3);
         n_vec++;
         if (bus.state_o !== 2'd3 || bus.early_o !== 1'b1) begin
            n_err++;
            $display("FAIL false_finish[%0d]: state=%0d early=%b expected 3/1", it, bus.state_o, bus.early_o);
         end
         bus.react_i = 1'b0;
         step(4);
         for (int c = 0; c < int'(2 * SD * ND); c++) begin
            step(1);
            n_vec++;
            if ({1'b0, bus.seg_o} !== exp_seg(bus.dig_sel_o, 0, 0, 1'b1)) begin
               n_err++;
               $display("FAIL false_disp[%0d]: seg=%h sel=%b expected 40", it, bus.seg_o, bus.dig_sel_o);
            end
         end
         if (it < 2) begin
            do_start(d);
            n_vec++;
            if (bus.state_o !== 2'd1 || bus.early_o !== 1'b0) begin
               n_err++;
               $display("FAIL false_restart[%0d]: state=%0d early=%b expected 1/0", it, bus.state_o, bus.early_o);
            end
         end
      end
   endtask

   task automatic test_timeout;
      int d;
      do_start(d);
      step(4 * d);
      step(399);
      n_vec++;
      if (bus.state_o !== 2'd2 || bus.timeout_o !== 1'b0) begin
         n_err++;
         $display("FAIL timeout_pre: state=%0d timeout=%b expected 2/0", bus.state_o, bus.timeout_o);
      end
      step(1);
      n_vec++;
      if (bus.state_o !== 2'd3 || bus.timeout_o !== 1'b1 || bus.early_o !== 1'b0) begin
         n_err++;
         $display("FAIL timeout_hit: state=%0d timeout=%b early=%b expected 3/1/0", bus.state_o, bus.timeout_o, bus.early_o);
      end
      step(3);
      for (int c = 0; c < int'(2 * SD * ND); c++) begin
         step(1);
         n_vec++;
         if ({1'b0, bus.seg_o} !== exp_seg(bus.dig_sel_o, 9, 9, 1'b0)) begin
            n_err++;
            $display("FAIL timeout_disp: seg=%h sel=%b expected 6F", bus.seg_o, bus.dig_sel_o);
         end
      end
   endtask

   task automatic test_ena_freeze;
      int            d;
      int            pre;
      logic [ND-1:0] sel0;
      do_start(d);
      step(4 * d);
      pre = int'($urandom_range(4, 16));
      step(pre);
      bus.ena = 1'b0;
      sel0    = bus.dig_sel_o;
      for (int c = 0; c < 50; c++) begin
         step(1);
         n_vec++;
         if (bus.state_o !== 2'd2 || bus.dig_sel_o !== sel0 || bus.seg_o !== 7'h00) begin
            n_err++;
            $display("FAIL ena_hold[%0d]: state=%0d sel=%b seg=%h expected 2/%b/00", c, bus.state_o, bus.dig_sel_o, bus.seg_o, sel0);
         end
      end
      bus.ena = 1'b1;
      // react lands exactly on the 5th tick edge (enabled edge 20), so that tick is dropped
      step(17 - pre);
      bus.react_i = 1'b1;
      step(3);
      n_vec++;
      if (bus.state_o !== 2'd3) begin
         n_err++;
         $display("FAIL ena_finish: state=%0d expected 3", bus.state_o);
      end
      bus.react_i = 1'b0;
      step(4);
      for (int c = 0; c < int'(2 * SD * ND); c++) begin
         step(1);
         n_vec++;
         if ({1'b0, bus.seg_o} !== exp_seg(bus.dig_sel_o, 0, 4, 1'b0)) begin
            n_err++;
            $display("FAIL ena_disp: seg=%h sel=%b expected %h", bus.seg_o, bus.dig_sel_o, exp_seg(bus.dig_sel_o, 0, 4, 1'b0));
         end
      end
   endtask

   task automatic test_reset_mid_play;
      int d;
      do_start(d);
      step(4 * d + 5);
      #2;
      rst_n = 1'b0;
      #1;
      n_vec++;
      if (bus.state_o !== 2'd0 || bus.seg_o !== 7'h00 || bus.dig_sel_o !== 2'b01 ||
          bus.early_o !== 1'b0 || bus.timeout_o !== 1'b0) begin
         n_err++;
         $display("FAIL midplay_reset: state=%0d seg=%h sel=%b early=%b timeout=%b expected 0/00/01/0/0", bus.state_o, bus.seg_o, bus.dig_sel_o, bus.early_o, bus.timeout_o);
      end
      @(negedge clk);
      rst_n = 1'b1;
      step(3);
      n_vec++;
      if (bus.state_o !== 2'd0 || bus.seg_o !== 7'h00) begin
         n_err++;
         $display("FAIL midplay_after: state=%0d seg=%h expected 0/00", bus.state_o, bus.seg_o);
      end
   endtask

`ifdef BEST_SCORE_EN
   task automatic test_best;
      int d;
      int s;
      int runs [3];
      runs  = '{12, 5, 9};
      rst_n = 1'b0;
      step(2);
      rst_n = 1'b1;
      step(2);
      for (int r = 0; r < 3; r++) begin
         do_start(d);
         step(4 * d);
         s = 4 * runs[r] - 2 + int'($urandom_range(0, 3));
         step(s);
         bus.react_i = 1'b1;
         step(3);
         n_vec++;
         if (bus.state_o !== 2'd3) begin
            n_err++;
            $display("FAIL best_finish[%0d]: state=%0d expected 3", r, bus.state_o);
         end
         if (r < 2) begin
            bus.react_i = 1'b0;
            step(6);
         end
      end
      step(4);
      for (int c = 0; c < int'(2 * SD * ND); c++) begin
         step(1);
         n_vec++;
         if ({1'b0, bus.seg_o} !== exp_seg(bus.dig_sel_o, 0, 5, 1'b0)) begin
            n_err++;
            $display("FAIL best_disp: seg=%h sel=%b expected %h", bus.seg_o, bus.dig_sel_o, exp_seg(bus.dig_sel_o, 0, 5, 1'b0));
         end
      end
      bus.react_i = 1'b0;
      step(4);
      for (int c = 0; c < int'(2 * SD * ND); c++) begin
         step(1);
         n_vec++;
         if ({1'b0, bus.seg_o} !== exp_seg(bus.dig_sel_o, 0, 9, 1'b0)) begin
            n_err++;
            $display("FAIL best_last_disp: seg=%h sel=%b expected %h", bus.seg_o, bus.dig_sel_o, exp_seg(bus.dig_sel_o, 0, 9, 1'b0));
         end
      end
   endtask
`endif

   initial begin
      codes = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
      test_reset();
      test_normal_run();
      test_random_runs();
      test_false_start();
      test_timeout();
      test_ena_freeze();
      test_reset_mid_play();
`ifdef BEST_SCORE_EN
      test_best();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
